// File: rtl/spi_mem_reader.sv
// SPI mode-0 master for the diagnostic memory-read protocol: sends {CMD_READ, addr} then clocks len bytes back.
// Optional build macro SPI_READER_ABORT_EN adds the abort input and aborted status output.
module spi_mem_reader #(
  parameter int          CLK_DIV  = 4,
  parameter logic [7:0]  CMD_READ = 8'h03
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [7:0]  len,
`ifdef SPI_READER_ABORT_EN
  input  logic        abort,
  output logic        aborted,
`endif
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HEADER, S_DATA, S_HOLD, S_GAP} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [DIV_W-1:0] r_div;
  logic [22:0]      r_shift;
  logic [6:0]       r_rx;
  logic [4:0]       r_hdr_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_byte_cnt;
  logic             r_hold;
  logic             r_fin;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_rd_data;
  logic             r_rd_valid;
  logic             r_sclk;
  logic             r_cs_n;
  logic             r_mosi;
  logic             w_tick;
  logic             w_accept;
  logic             w_abort;
  logic             w_last_bit;
  logic [7:0]       w_rx_byte;

  assign w_tick     = (r_div == DIV_LAST);
  // A start coinciding with the done pulse is deliberately dropped.
  assign w_accept   = (r_state == S_IDLE) && start && !r_busy && !r_done;
  assign w_last_bit = (r_bit_cnt == 3'd7) && (r_byte_cnt == 8'd1);
  assign w_rx_byte  = {r_rx, spi_miso};

`ifdef SPI_READER_ABORT_EN
  logic r_aborted;
  assign w_abort = abort && r_busy && (r_state != S_GAP) && (r_state != S_IDLE);
  assign aborted = r_aborted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_aborted <= 1'b0;
    else if (w_accept) r_aborted <= 1'b0;
    else if (w_abort)  r_aborted <= 1'b1;
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && (len != 8'd0))                  w_state_nx = S_SETUP;
      S_SETUP:  if (w_tick)                                      w_state_nx = S_HEADER;
      S_HEADER: if (w_tick && r_sclk && (r_hdr_cnt == 5'd23))   w_state_nx = S_DATA;
      S_DATA:   if (w_tick && r_sclk && w_last_bit)             w_state_nx = S_HOLD;
      S_HOLD:   if (w_tick && r_hold)                            w_state_nx = S_GAP;
      S_GAP:    if (w_tick)                                      w_state_nx = S_IDLE;
      default:                                                   w_state_nx = S_IDLE;
    endcase
    if (w_abort) w_state_nx = S_GAP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div      <= '0;
      r_hdr_cnt  <= 5'd0;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 8'd0;
      r_hold     <= 1'b0;
      r_fin      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      if (r_state != S_IDLE) r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_abort) begin
        r_sclk <= 1'b0;
        r_mosi <= 1'b0;
        r_cs_n <= 1'b1;
        r_div  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_fin) begin
              r_fin  <= 1'b0;
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end else if (w_accept) begin
              r_busy     <= 1'b1;
              r_hdr_cnt  <= 5'd0;
              r_bit_cnt  <= 3'd0;
              r_byte_cnt <= len;
              r_hold     <= 1'b0;
              if (len == 8'd0) begin
                r_fin <= 1'b1;
              end else begin
                r_cs_n <= 1'b0;
                r_mosi <= CMD_READ[7];
              end
            end
          end
          S_SETUP: if (w_tick) r_sclk <= 1'b1;
          S_HEADER: begin
            if (w_tick) begin
              if (!r_sclk) begin
                r_sclk <= 1'b1;
              end else begin
                r_sclk    <= 1'b0;
                r_hdr_cnt <= r_hdr_cnt + 5'd1;
                r_mosi    <= (r_hdr_cnt == 5'd23) ? 1'b0 : r_shift[22];
              end
            end
          end
          S_DATA: begin
            if (w_tick) begin
              if (!r_sclk) begin
                r_sclk <= 1'b1;
              end else begin
                r_sclk    <= 1'b0;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                  r_rd_valid <= 1'b1;
                  r_rd_data  <= w_rx_byte;
                  r_byte_cnt <= r_byte_cnt - 8'd1;
                end
              end
            end
          end
          // Two ticks: trailing low half of the last SCK period, then the cs hold tick.
          S_HOLD: begin
            if (w_tick) begin
              if (r_hold) r_cs_n <= 1'b1;
              else        r_hold <= 1'b1;
            end
          end
          S_GAP: if (w_tick) r_fin <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_shift <= {CMD_READ[6:0], addr};
    else if ((r_state == S_HEADER) && w_tick && r_sclk)
      r_shift <= {r_shift[21:0], 1'b0};
    if ((r_state == S_DATA) && w_tick && r_sclk)
      r_rx <= w_rx_byte[6:0];
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign spi_clk  = r_sclk;
  assign spi_cs_n = r_cs_n;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_mem_reader.sv
// Self-checking bench for spi_mem_reader: table of read transactions plus reset, len=255,
// ignored-start and reset-mid-data sequences against a bus-level slave model.
module tb_spi_mem_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  len = 8'h00;
  logic        spi_miso = 1'b1;
  logic        busy, done, rd_valid, spi_clk, spi_cs_n, spi_mosi;
  logic [7:0]  rd_data;
`ifdef SPI_READER_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
`endif

  spi_mem_reader #(.CLK_DIV(4), .CMD_READ(8'h03)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .len(len),
`ifdef SPI_READER_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave memory and bus observations, owned by the monitor process.
  logic [7:0]  slave_mem [256];
  int          clr_seq = 0, seen_seq = 0;
  int          cyc = 0;
  int          rise_cnt, cs_bad, cs_low, rv_cnt, done_cnt;
  int          t_acc, t_done, t_csr, t_rise1;
  logic [23:0] hdr;
  logic [7:0]  rv_data [256];
  int          t_rv [256];
  logic        p_sclk = 1'b0, p_cs = 1'b1, p_busy = 1'b0;
  int          idx;
  logic [7:0]  mb;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (clr_seq != seen_seq) begin
        seen_seq = clr_seq;
        rise_cnt = 0; cs_bad = 0; cs_low = 0; rv_cnt = 0; done_cnt = 0;
        t_acc = -1; t_done = -1; t_csr = -1; t_rise1 = -1; hdr = 24'h0;
      end
      if (!reset_n) begin
        spi_miso = 1'b1;
      end else begin
        if (spi_clk && !p_sclk) begin
          rise_cnt++;
          if (rise_cnt == 1) t_rise1 = cyc;
          if (spi_cs_n) cs_bad++;
          if (rise_cnt <= 24) hdr = {hdr[22:0], spi_mosi};
        end
        if (!spi_clk && p_sclk && rise_cnt >= 24) begin
          idx = rise_cnt - 24;
          mb = slave_mem[(idx / 8) % 256];
          spi_miso = mb[7 - (idx % 8)];
        end
        if (!spi_cs_n) cs_low++;
        if (spi_cs_n && !p_cs) t_csr = cyc;
        if (busy && !p_busy) t_acc = cyc;
        if (rd_valid) begin
          if (rv_cnt < 256) begin
            rv_data[rv_cnt] = rd_data;
            t_rv[rv_cnt] = cyc;
          end
          rv_cnt++;
        end
        if (done) begin
          done_cnt++;
          t_done = cyc;
        end
      end
      p_sclk = spi_clk; p_cs = spi_cs_n; p_busy = busy;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic kick(input logic [15:0] a, input logic [7:0] l);
    @(negedge clk); #1;
    clr_seq++;
    @(negedge clk); #1;
    addr = a; len = l; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(nm, done_cnt, 1);
  endtask

  task automatic wait_rises(input int target, input string nm);
    int n = 0;
    while (rise_cnt < target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk(nm, rise_cnt, target);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  l;
    logic [7:0]  d0, d1, d2;
    logic [23:0] exp_hdr;
    int          exp_rises;
    int          exp_done_lat;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [7:0] d [3];
    int         td;
    int         bad;

    tbl[0] = '{16'h0007, 8'd1, 8'hC2, 8'h00, 8'h00, 24'h030007, 32, 269};
    tbl[1] = '{16'hA55A, 8'd3, 8'hC2, 8'h55, 8'hAA, 24'h03A55A, 48, 397};
    tbl[2] = '{16'hFFFF, 8'd2, 8'h00, 8'hFF, 8'h00, 24'h03FFFF, 40, 333};
    tbl[3] = '{16'h8001, 8'd0, 8'h11, 8'h22, 8'h33, 24'h000000, 0, 1};
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;

    // Reset held with miso high and start toggling.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      start = ~start;
      addr = 16'h1234; len = 8'd4;
      chk("reset_outs", {31'd0, spi_cs_n}, 32'd1);
      chk("reset_quiet", {26'd0, spi_clk, busy, rd_valid, done, spi_mosi, 1'b0}, 32'd0);
    end
    chk("reset_rd_data", {24'd0, rd_data}, 32'd0);
    start = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_after_reset", {30'd0, busy, spi_cs_n}, 32'd1);

    for (int v = 0; v < 4; v++) begin
      slave_mem[0] = tbl[v].d0; slave_mem[1] = tbl[v].d1; slave_mem[2] = tbl[v].d2;
      d[0] = tbl[v].d0; d[1] = tbl[v].d1; d[2] = tbl[v].d2;
      kick(tbl[v].a, tbl[v].l);
      wait_done(1000, "tbl_done_seen");
      repeat (10) @(negedge clk);
      #1;
      chk("tbl_done_once", done_cnt, 1);
      chk("tbl_busy_end", {31'd0, busy}, 32'd0);
      chk("tbl_header", {8'd0, hdr}, {8'd0, tbl[v].exp_hdr});
      chk("tbl_rises", rise_cnt, tbl[v].exp_rises);
      chk("tbl_rv_count", rv_cnt, {24'd0, tbl[v].l});
      chk("tbl_done_lat", t_done - t_acc, tbl[v].exp_done_lat);
      if (tbl[v].l == 8'd0) begin
        chk("len0_cs_never_low", cs_low, 0);
      end else begin
        chk("tbl_cs_low_at_rises", cs_bad, 0);
        chk("tbl_first_rise_lat", t_rise1 - t_acc, 4);
        chk("tbl_cs_to_done", t_done - t_csr, 5);
      end
      for (int k = 0; k < int'(tbl[v].l); k++) begin
        chk("tbl_rd_data", {24'd0, rv_data[k]}, {24'd0, d[k]});
        chk("tbl_rv_lat", t_rv[k] - t_acc, 8 * (24 + 8 * (k + 1)));
      end
    end

    // len=255: full byte counter range.
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'(i * 7 + 3);
    kick(16'hC000, 8'd255);
    wait_done(20000, "len255_done_seen");
    chk("len255_rv_count", rv_cnt, 255);
    chk("len255_rises", rise_cnt, 2064);
    chk("len255_done_lat", t_done - t_acc, 16525);
    bad = 0;
    for (int i = 0; i < 255; i++) if (rv_data[i] !== 8'(i * 7 + 3)) bad++;
    chk("len255_bytes", bad, 0);
    chk("len255_last_byte", {24'd0, rv_data[254]}, 32'h000000F5);

    // Start during DATA is ignored; start during done is ignored, next cycle accepted.
    slave_mem[0] = 8'hC2; slave_mem[1] = 8'h55; slave_mem[2] = 8'hAA;
    kick(16'h4321, 8'd3);
    wait_rises(30, "ign_reach_data");
    addr = 16'hBEEF; len = 8'd5; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(1000, "ign_done_seen");
    chk("ign_header", {8'd0, hdr}, 32'h00034321);
    chk("ign_rv_count", rv_cnt, 3);
    chk("ign_rises", rise_cnt, 48);
    chk("ign_last_byte", {24'd0, rv_data[2]}, 32'h000000AA);
    td = t_done;
    clr_seq++;
    addr = 16'h0A0B; len = 8'd1; start = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("restart_accept_lat", t_acc - td, 2);
    wait_done(1000, "restart_done_seen");
    chk("restart_header", {8'd0, hdr}, 32'h00030A0B);
    chk("restart_rises", rise_cnt, 32);

    // Asynchronous reset at the 5th data bit.
    kick(16'h00F0, 8'd2);
    wait_rises(29, "rst_reach_bit5");
    reset_n = 1'b0;
    #1;
    chk("rst_async_cs", {31'd0, spi_cs_n}, 32'd1);
    chk("rst_async_quiet", {29'd0, spi_clk, busy, rd_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rst_no_pulse", {30'd0, rd_valid, done}, 32'd0);
    end
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("rst_no_rv_after", rv_cnt, 0);
    chk("rst_no_done_after", done_cnt, 0);
    slave_mem[0] = 8'h3C;
    kick(16'h5A5A, 8'd1);
    wait_done(1000, "post_rst_done_seen");
    chk("post_rst_header", {8'd0, hdr}, 32'h00035A5A);
    chk("post_rst_rises", rise_cnt, 32);
    chk("post_rst_byte", {24'd0, rv_data[0]}, 32'h0000003C);

`ifdef SPI_READER_ABORT_EN
    kick(16'h1111, 8'd2);
    wait_rises(29, "abt_reach_bit5");
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    chk("abt_sclk_low", {30'd0, spi_clk, spi_mosi}, 32'd0);
    wait_done(100, "abt_done_seen");
    chk("abt_flag", {31'd0, aborted}, 32'd1);
    chk("abt_no_rv", rv_cnt, 0);
    kick(16'h2222, 8'd1);
    chk("abt_flag_cleared", {31'd0, aborted}, 32'd0);
    wait_done(1000, "abt_next_done_seen");
    chk("abt_next_rv", rv_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
